kv_line_fetch: RTL and testbench

//  Memory-side line-fill engine for KVCache. Accepts one line-miss request (fetch addr/valid/ready),

---
 rtl/kv_line_fetch.sv | 136 +++++++++++++
 tb/tb_kv_line_fetch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kv_line_fetch.sv
// kv_line_fetch: line-fill engine between the cache miss port and a word-wide memory port.
// Takes one miss request and issues LINE_SIZE pipelined single-word reads. It collects the
// in-order responses into a line buffer and presents the full line to the cache.
// Ports:
//   i_clk, i_rst                         clock, asynchronous active-high reset
//   i_fetch_addr/valid, o_fetch_ready    miss request channel (one line in flight)
//   o_line_data/valid, i_line_ready      assembled line channel, word 0 = lowest address
//   o_mem_addr/valid, i_mem_ready        memory read request channel
//   i_mem_data/valid                     memory read response (in order, always accepted)
module kv_line_fetch #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LINE_SIZE  = 4
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic [ADDR_WIDTH-1:0]                 i_fetch_addr,
   input  logic                                  i_fetch_valid,
   output logic                                  o_fetch_ready,
   output logic [LINE_SIZE-1:0][DATA_WIDTH-1:0]  o_line_data,
   output logic                                  o_line_valid,
   input  logic                                  i_line_ready,
   output logic [ADDR_WIDTH-1:0]                 o_mem_addr,
   output logic                                  o_mem_valid,
   input  logic                                  i_mem_ready,
   input  logic [DATA_WIDTH-1:0]                 i_mem_data,
   input  logic                                  i_mem_valid
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned IDX_W = $clog2(LINE_SIZE);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam int unsigned OFF_W = $clog2(LINE_SIZE * BYTES);
   localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(LINE_SIZE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 state, state_next;
   logic [CNT_W-1:0]       issue_cnt, issue_next;
   logic [CNT_W-1:0]       recv_cnt, recv_next;
   logic [ADDR_WIDTH-1:0]  base, base_next;
   logic                   line_we;
   logic                   fetch_ready_next;
   logic                   line_valid_next;
   logic                   mem_valid_next;
   logic [ADDR_WIDTH-1:0]  mem_addr_next;

   // Offset bits inside the line are dropped when the base is latched.
   logic unused_addr_bits;
   assign unused_addr_bits = ^i_fetch_addr[OFF_W-1:0];

   // Next-state, counter and registered-output logic.
   always_comb begin
      state_next = state;
      issue_next = issue_cnt;
      recv_next  = recv_cnt;
      base_next  = base;
      line_we    = 1'b0;

      case (state)
         ST_IDLE: begin
            // Responses arriving here belong to no line and are dropped.
            if (i_fetch_valid) begin
               base_next  = {i_fetch_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
               issue_next = '0;
               recv_next  = '0;
               state_next = ST_FILL;
            end
         end
         ST_FILL: begin
            if (o_mem_valid && i_mem_ready) begin
               issue_next = issue_cnt + CNT_W'(1);
            end
            // Only responses to already-issued reads are accepted.
            if (i_mem_valid && (recv_cnt < issue_cnt)) begin
               line_we   = 1'b1;
               recv_next = recv_cnt + CNT_W'(1);
            end
            if (recv_cnt == LINE_CNT) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_line_ready) begin
               issue_next = '0;
               recv_next  = '0;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      fetch_ready_next = (state_next == ST_IDLE);
      line_valid_next  = (state_next == ST_DONE);
      mem_valid_next   = (state_next == ST_FILL) && (issue_next < LINE_CNT);
      // Address only moves when a new request is presented, so it holds while stalled.
      mem_addr_next    = o_mem_addr;
      if (mem_valid_next) begin
         mem_addr_next = base_next + ADDR_WIDTH'(issue_next) * ADDR_WIDTH'(BYTES);
      end
   end

   // State, counters, registered outputs and line buffer.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= ST_IDLE;
         issue_cnt     <= '0;
         recv_cnt      <= '0;
         base          <= '0;
         o_fetch_ready <= 1'b1;
         o_line_valid  <= 1'b0;
         o_mem_valid   <= 1'b0;
         o_mem_addr    <= '0;
         o_line_data   <= '0;
      end else begin
         state         <= state_next;
         issue_cnt     <= issue_next;
         recv_cnt      <= recv_next;
         base          <= base_next;
         o_fetch_ready <= fetch_ready_next;
         o_line_valid  <= line_valid_next;
         o_mem_valid   <= mem_valid_next;
         o_mem_addr    <= mem_addr_next;
         if (line_we) begin
            o_line_data[recv_cnt[IDX_W-1:0]] <= i_mem_data;
         end
      end
   end

endmodule

// File: tb/tb_kv_line_fetch.sv
// tb_kv_line_fetch: scoreboard bench for kv_line_fetch. Fetch stimulus pushes the expected
// request addresses and line contents. A negedge monitor pops and compares them whenever the
// DUT presents a read request or a line. A small memory model answers accepted reads with
// addr ^ 0xA5A5_A5A5 after a configurable latency.
module tb_kv_line_fetch;

   logic              clk;
   logic              rst;
   logic [31:0]       i_fetch_addr;
   logic              i_fetch_valid;
   logic              o_fetch_ready;
   logic [3:0][31:0]  o_line_data;
   logic              o_line_valid;
   logic              i_line_ready;
   logic [31:0]       o_mem_addr;
   logic              o_mem_valid;
   logic              i_mem_ready;
   logic [31:0]       i_mem_data;
   logic              i_mem_valid;

   kv_line_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LINE_SIZE(4)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_fetch_addr  (i_fetch_addr),
      .i_fetch_valid (i_fetch_valid),
      .o_fetch_ready (o_fetch_ready),
      .o_line_data   (o_line_data),
      .o_line_valid  (o_line_valid),
      .i_line_ready  (i_line_ready),
      .o_mem_addr    (o_mem_addr),
      .o_mem_valid   (o_mem_valid),
      .i_mem_ready   (i_mem_ready),
      .i_mem_data    (i_mem_data),
      .i_mem_valid   (i_mem_valid)
   );

   localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;

   typedef struct {
      int          acc;
      logic [31:0] addr;
   } pend_t;

   int               total = 0;
   int               bad   = 0;
   int               cyc   = 0;
   int               t0    = 0;
   int               lat   = 1;
   bit               stall_mode = 0;
   int               spur_until = 0;
   logic [31:0]      exp_addr_q[$];
   logic [127:0]     exp_line_q[$];
   pend_t            pend[$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Memory model: ready pattern, in-order responses after lat edges, spurious words on request.
   initial begin
      pend_t p;
      i_mem_valid = 1'b0;
      i_mem_data  = '0;
      i_mem_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         i_mem_ready = stall_mode ? cyc[0] : 1'b1;
         if (rst) begin
            pend.delete();
            i_mem_valid = 1'b0;
            i_mem_data  = '0;
         end else if (cyc < spur_until) begin
            i_mem_valid = 1'b1;
            i_mem_data  = 32'hDEAD_BEEF;
         end else if (pend.size() > 0 && (pend[0].acc + lat <= cyc + 1)) begin
            p = pend.pop_front();
            i_mem_valid = 1'b1;
            i_mem_data  = p.addr ^ XOR_KEY;
         end else begin
            i_mem_valid = 1'b0;
            i_mem_data  = '0;
         end
      end
   end

   // Monitor: compare presented requests and lines against the scoreboard queues.
   initial begin
      pend_t p;
      forever begin
         @(negedge clk);
         if (!rst && o_mem_valid) begin
            if (exp_addr_q.size() == 0) begin
               chk("mem_req_extra", 128'(o_mem_addr), 128'(0));
            end else begin
               chk("mem_addr", 128'(o_mem_addr), 128'(exp_addr_q[0]));
               if (i_mem_ready) begin
                  void'(exp_addr_q.pop_front());
                  p.acc  = cyc + 1;
                  p.addr = o_mem_addr;
                  pend.push_back(p);
               end
            end
         end
         if (!rst && o_line_valid) begin
            if (exp_line_q.size() == 0) begin
               chk("line_extra", 128'(o_line_data), 128'(0));
            end else begin
               chk("line_data", 128'(o_line_data), exp_line_q[0]);
               if (i_line_ready) void'(exp_line_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Drive one request and push its expected reads and line; returns one step after the accept edge.
   task automatic start_fetch(input logic [31:0] a);
      logic [31:0]  b;
      logic [127:0] ln;
      b = {a[31:4], 4'h0};
      for (int i = 0; i < 4; i++) begin
         exp_addr_q.push_back(b + 32'(4 * i));
         ln[32*i +: 32] = (b + 32'(4 * i)) ^ XOR_KEY;
      end
      exp_line_q.push_back(ln);
      i_fetch_addr  = a;
      i_fetch_valid = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      i_fetch_valid = 1'b0;
      i_fetch_addr  = 32'h0;
   endtask

   bit fr_high;

   task automatic wait_line(input bit chk_lat);
      bit seen = 0;
      fr_high = 0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         if (o_line_valid) seen = 1;
         else if (o_fetch_ready) fr_high = 1;
      end
      if (!seen) chk("line_timeout", 128'(0), 128'(1));
      else if (chk_lat) chk("line_latency", 128'(cyc - t0), 128'(6));
   endtask

   task automatic wait_idle();
      bit seen = 0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         if (o_fetch_ready) seen = 1;
      end
      chk("idle_reached", 128'(seen), 128'(1));
      chk("fetch_ready_busy", 128'(fr_high), 128'(0));
   endtask

   initial begin
      rst           = 1'b1;
      i_fetch_addr  = '0;
      i_fetch_valid = 1'b0;
      i_line_ready  = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_fetch_ready", 128'(o_fetch_ready), 128'(1));
      chk("rst_line_valid",  128'(o_line_valid),  128'(0));
      chk("rst_mem_valid",   128'(o_mem_valid),   128'(0));
      chk("rst_mem_addr",    128'(o_mem_addr),    128'(0));
      chk("rst_line_data",   128'(o_line_data),   128'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Zero-stall fill, unaligned address, latency to line valid
      start_fetch(32'h1111_1001);
      wait_line(1);
      wait_idle();

      // Stalling memory and three-cycle response latency
      stall_mode = 1;
      lat        = 3;
      start_fetch(32'h1111_1001);
      wait_line(0);
      wait_idle();
      stall_mode = 0;
      lat        = 1;

      // Backpressure in DONE while a new request is offered
      i_line_ready = 1'b0;
      start_fetch(32'h2000_0038);
      wait_line(1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         i_fetch_valid = 1'b1;
         i_fetch_addr  = 32'h5555_0000;
         @(negedge clk);
         chk("done_line_valid",  128'(o_line_valid),  128'(1));
         chk("done_mem_valid",   128'(o_mem_valid),   128'(0));
         chk("done_fetch_ready", 128'(o_fetch_ready), 128'(0));
      end
      @(posedge clk);
      #1;
      i_fetch_valid = 1'b0;
      i_fetch_addr  = 32'h0;
      i_line_ready  = 1'b1;
      @(posedge clk);
      #1;
      chk("consume_line_valid",  128'(o_line_valid),  128'(0));
      chk("consume_fetch_ready", 128'(o_fetch_ready), 128'(1));
      chk("consume_mem_valid",   128'(o_mem_valid),   128'(0));

      // Top-of-address line, then spurious responses in IDLE
      start_fetch(32'hFFFF_FFF4);
      wait_line(1);
      wait_idle();
      @(posedge clk);
      #1;
      spur_until = cyc + 3;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("spur_fetch_ready", 128'(o_fetch_ready), 128'(1));
      chk("spur_line_valid",  128'(o_line_valid),  128'(0));
      chk("spur_mem_valid",   128'(o_mem_valid),   128'(0));
      @(posedge clk);
      #1;
      start_fetch(32'h0000_0104);
      wait_line(1);
      wait_idle();

      // Reset after two of four responses, then a clean fill
      @(posedge clk);
      #1;
      start_fetch(32'h3000_0000);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_fetch_ready", 128'(o_fetch_ready), 128'(1));
      chk("midrst_line_valid",  128'(o_line_valid),  128'(0));
      chk("midrst_mem_valid",   128'(o_mem_valid),   128'(0));
      exp_addr_q.delete();
      exp_line_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      start_fetch(32'h0000_0040);
      wait_line(1);
      wait_idle();

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("addr_queue_empty", 128'(exp_addr_q.size()), 128'(0));
      chk("line_queue_empty", 128'(exp_line_q.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
